// File: rtl/call_return_unit_pkg.sv
// Shared definitions for the call/return unit.
// State encoding and request latencies.
package call_return_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUSH = 2'd1,
        ST_POP  = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam int CALL_LAT = 1;
    localparam int RET_LAT  = 3;

endpackage

// File: rtl/call_return_unit_if.sv
// Bus between the call/return unit and its return-address stack.
// master = call/return unit, slave = stack.
interface call_return_unit_if #(
    parameter int width = 16
);

    logic [width-1:0] stk_data;
    logic             stk_push;
    logic             stk_pop;
    logic [width-1:0] stk_q;
    logic             stk_empty;
    logic             stk_full;

    modport master (
        output stk_data, stk_push, stk_pop,
        input  stk_q, stk_empty, stk_full
    );

    modport slave (
        input  stk_data, stk_push, stk_pop,
        output stk_q, stk_empty, stk_full
    );

endinterface

// File: rtl/crs_stack.sv
// Return-address stack; stk_q is registered on pop,
// so popped data is valid the cycle after stk_pop.
module crs_stack #(
    parameter int width = 16,
    parameter int depth = 16
) (
    input logic clock,
    input logic reset,
    call_return_unit_if.slave stk
);

    localparam int PW = $clog2(depth + 1);
    localparam int AW = (depth > 1) ? $clog2(depth) : 1;

    logic [width-1:0] r_mem [depth];
    logic [PW-1:0]    r_sp;
    logic [width-1:0] r_q;
    logic [AW-1:0]    w_wr;
    logic [AW-1:0]    w_rd;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_wr      = r_sp[AW-1:0];
    assign w_rd      = w_wr - 1'b1;
    assign w_do_push = stk.stk_push && !stk.stk_full;
    assign w_do_pop  = stk.stk_pop && !stk.stk_empty;

    always_ff @(posedge clock) begin
        if (w_do_push)
            r_mem[w_wr] <= stk.stk_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sp <= '0;
            r_q  <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + 1'b1;
        end else if (w_do_pop) begin
            r_sp <= r_sp - 1'b1;
            r_q  <= r_mem[w_rd];
        end
    end

    assign stk.stk_q     = r_q;
    assign stk.stk_empty = (r_sp == '0);
    assign stk.stk_full  = (r_sp == PW'(depth));

endmodule

// File: rtl/call_return_unit.sv
// Call/return sequencer: pushes return addresses on call,
// pops them on ret, and emits a one-cycle PC load strobe.
module call_return_unit
    import call_return_unit_pkg::*;
#(
    parameter int width = 16,
    parameter int depth = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       call,
    input  logic                       ret,
    input  logic [width-1:0]           pc_in,
    input  logic [width-1:0]           target,
    output logic [width-1:0]           pc_out,
    output logic                       pc_load,
    output logic                       busy,
    output logic                       overflow,
    output logic                       underflow,
    output logic [$clog2(depth+1)-1:0] level,
    call_return_unit_if.master         stk
);

    localparam int LW = $clog2(depth + 1);
    localparam logic [LW-1:0] LMAX = LW'(depth);

    state_t           r_state, w_state;
    logic [width-1:0] r_pc_out, w_pc_out;
    logic [width-1:0] r_stk_data, w_stk_data;
    logic             r_pc_load, w_pc_load;
    logic             r_push, w_push;
    logic             r_pop, w_pop;
    logic             r_ovf, w_ovf;
    logic             r_udf, w_udf;
    logic [LW-1:0]    r_level, w_level;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_pc_out   <= '0;
            r_stk_data <= '0;
            r_pc_load  <= 1'b0;
            r_push     <= 1'b0;
            r_pop      <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
            r_level    <= '0;
        end else begin
            r_state    <= w_state;
            r_pc_out   <= w_pc_out;
            r_stk_data <= w_stk_data;
            r_pc_load  <= w_pc_load;
            r_push     <= w_push;
            r_pop      <= w_pop;
            r_ovf      <= w_ovf;
            r_udf      <= w_udf;
            r_level    <= w_level;
        end
    end

    // Strobes are registered, so they are set on the edge entering PUSH/POP.
    always_comb begin
        w_state    = r_state;
        w_pc_out   = r_pc_out;
        w_stk_data = r_stk_data;
        w_pc_load  = 1'b0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_ovf      = r_ovf;
        w_udf      = r_udf;
        w_level    = r_level;
        unique case (r_state)
            ST_IDLE: begin
                if (call) begin
                    if (stk.stk_full) begin
                        w_ovf = 1'b1;
                    end else begin
                        w_stk_data = pc_in + width'(1);
                        w_pc_out   = target;
                        w_pc_load  = 1'b1;
                        w_push     = 1'b1;
                        w_state    = ST_PUSH;
                        if (r_level != LMAX)
                            w_level = r_level + 1'b1;
                    end
                end else if (ret) begin
                    if (stk.stk_empty) begin
                        w_udf = 1'b1;
                    end else begin
                        w_pop   = 1'b1;
                        w_state = ST_POP;
                        if (r_level != '0)
                            w_level = r_level - 1'b1;
                    end
                end
            end
            ST_PUSH: w_state = ST_IDLE;
            ST_POP:  w_state = ST_WAIT;
            ST_WAIT: begin
                w_pc_out  = stk.stk_q;
                w_pc_load = 1'b1;
                w_state   = ST_IDLE;
            end
        endcase
    end

    assign pc_out       = r_pc_out;
    assign pc_load      = r_pc_load;
    assign busy         = (r_state != ST_IDLE);
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
    assign level        = r_level;
    assign stk.stk_data = r_stk_data;
    assign stk.stk_push = r_push;
    assign stk.stk_pop  = r_pop;

endmodule

// File: tb/tb_call_return_unit.sv
// Directed bench for call_return_unit with its stack attached;
// expected PC loads are queued at stimulus and popped on pc_load.
module tb_call_return_unit;
    import call_return_unit_pkg::*;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int LW = $clog2(D + 1);

    logic          clock = 1'b0;
    logic          reset;
    logic          call;
    logic          ret;
    logic [W-1:0]  pc_in;
    logic [W-1:0]  target;
    logic [W-1:0]  pc_out;
    logic          pc_load;
    logic          busy;
    logic          overflow;
    logic          underflow;
    logic [LW-1:0] level;

    int n_err = 0;
    int n_chk = 0;
    int n_load = 0;
    int base;
    logic [W-1:0] exp_q [$];

    call_return_unit_if #(.width(W)) stk_if ();

    call_return_unit #(.width(W), .depth(D)) dut (
        .clock(clock), .reset(reset), .call(call), .ret(ret),
        .pc_in(pc_in), .target(target), .pc_out(pc_out),
        .pc_load(pc_load), .busy(busy), .overflow(overflow),
        .underflow(underflow), .level(level), .stk(stk_if)
    );

    crs_stack #(.width(W), .depth(D)) u_stk (
        .clock(clock), .reset(reset), .stk(stk_if)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge and score any PC load.
    task automatic tick();
        @(posedge clock);
        #1;
        chk("push_pop_excl", 32'(stk_if.stk_push & stk_if.stk_pop), 0);
        if (pc_load) begin
            n_load++;
            if (exp_q.size() == 0)
                chk("spurious_load", 32'(pc_out), 32'hFFFF_FFFF);
            else
                chk("pc_out", 32'(pc_out), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        reset = 1'b0; call = 1'b0; ret = 1'b0;
        pc_in = '0; target = '0;
        tick(); tick();
        reset = 1'b1;
        chk("rst_pc_out", 32'(pc_out), 0);
        chk("rst_pc_load", 32'(pc_load), 0);
        chk("rst_level", 32'(level), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({overflow, underflow}), 0);
        chk("rst_stk_data", 32'(stk_if.stk_data), 0);

        // single call: latency CALL_LAT
        call = 1'b1; pc_in = 16'h0010; target = 16'h0200;
        exp_q.push_back(16'h0200);
        repeat (CALL_LAT) tick();
        call = 1'b0;
        chk("call_push", 32'(stk_if.stk_push), 1);
        chk("call_data", 32'(stk_if.stk_data), 32'h11);
        chk("call_load", 32'(pc_load), 1);
        chk("call_level", 32'(level), 1);
        tick();
        chk("call_push_1cyc", 32'(stk_if.stk_push), 0);
        chk("call_load_1cyc", 32'(pc_load), 0);
        chk("call_idle", 32'(busy), 0);

        // single ret: latency RET_LAT
        ret = 1'b1;
        exp_q.push_back(16'h0011);
        tick();
        ret = 1'b0;
        chk("ret_pop", 32'(stk_if.stk_pop), 1);
        chk("ret_level", 32'(level), 0);
        chk("ret_no_early_load", 32'(pc_load), 0);
        tick();
        chk("ret_pop_1cyc", 32'(stk_if.stk_pop), 0);
        chk("ret_wait_busy", 32'(busy), 1);
        tick();
        chk("ret_load", 32'(pc_load), 1);
        tick();
        chk("ret_load_1cyc", 32'(pc_load), 0);

        // nested calls then rets
        for (int i = 1; i <= 3; i++) begin
            call = 1'b1; pc_in = W'(16 * i); target = W'(256 * i);
            exp_q.push_back(W'(256 * i));
            tick(); call = 1'b0; tick();
        end
        chk("nest_level", 32'(level), 3);
        exp_q.push_back(16'h0031);
        exp_q.push_back(16'h0021);
        exp_q.push_back(16'h0011);
        for (int i = 0; i < 3; i++) begin
            ret = 1'b1; tick(); ret = 1'b0;
            repeat (RET_LAT - 1) tick();
            tick();
        end
        chk("nest_level_end", 32'(level), 0);

        // call and ret together: call wins
        call = 1'b1; ret = 1'b1; pc_in = 16'h0040; target = 16'h0400;
        exp_q.push_back(16'h0400);
        tick();
        call = 1'b0; ret = 1'b0;
        chk("both_push", 32'(stk_if.stk_push), 1);
        chk("both_no_pop", 32'(stk_if.stk_pop), 0);
        tick();
        chk("both_level", 32'(level), 1);
        chk("both_no_udf", 32'(underflow), 0);

        // ret held high through POP and WAIT is not re-accepted
        ret = 1'b1;
        exp_q.push_back(16'h0041);
        tick(); tick(); tick();
        ret = 1'b0;
        base = n_load;
        tick(); tick(); tick(); tick();
        chk("busy_ret_level", 32'(level), 0);
        chk("busy_ret_udf", 32'(underflow), 0);
        chk("busy_ret_no_load", 32'(n_load - base), 0);

        // underflow after reset
        reset = 1'b0; tick(); reset = 1'b1;
        base = n_load;
        ret = 1'b1; tick(); ret = 1'b0;
        chk("udf_flag", 32'(underflow), 1);
        chk("udf_no_pop", 32'(stk_if.stk_pop), 0);
        chk("udf_idle", 32'(busy), 0);
        tick(); tick(); tick();
        chk("udf_no_load", 32'(n_load - base), 0);

        // fill the stack, then one more call overflows
        for (int i = 0; i < D; i++) begin
            call = 1'b1; pc_in = W'(i); target = W'(16'h1000 + i);
            exp_q.push_back(W'(16'h1000 + i));
            tick(); call = 1'b0; tick();
        end
        chk("full_level", 32'(level), D);
        chk("full_no_ovf", 32'(overflow), 0);
        base = n_load;
        call = 1'b1; pc_in = 16'h0077; target = 16'h0777;
        tick(); call = 1'b0;
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_no_push", 32'(stk_if.stk_push), 0);
        chk("ovf_idle", 32'(busy), 0);
        tick();
        chk("ovf_no_load", 32'(n_load - base), 0);
        chk("ovf_level_sat", 32'(level), D);
        chk("udf_sticky", 32'(underflow), 1);

        // reset in WAIT aborts the pending load
        ret = 1'b1; tick(); ret = 1'b0;
        tick();
        chk("wait_busy", 32'(busy), 1);
        reset = 1'b0; tick(); reset = 1'b1;
        chk("wrst_load", 32'(pc_load), 0);
        chk("wrst_idle", 32'(busy), 0);
        chk("wrst_flags", 32'({overflow, underflow}), 0);
        chk("wrst_level", 32'(level), 0);
        tick();
        chk("wrst_no_load", 32'(pc_load), 0);

        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
